// File: rtl/piso_rr_pkg.sv
// Shared types and constants for the round-robin PISO scheduler.
// Contents:
//   state_t        scheduler FSM states (GUARD only reachable with PISO_RR_GUARD_EN)
//   DATA_WIDTH_C   width of one parallel word (matches the 32-bit PISO)
//   BIT_INDEX_W_C  width of the serial bit index
//   ID_W_C         width of a requester ID (supports up to 8 requesters)
package piso_rr_pkg;

  localparam int DATA_WIDTH_C  = 32;
  localparam int BIT_INDEX_W_C = 5;
  localparam int ID_W_C        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GUARD = 2'd3
  } state_t;

endpackage

// File: rtl/piso_rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   valid   [NUM_REQ-1:0]  per-requester request
//   pointer [ID_W_C-1:0]   highest-priority requester this round (< NUM_REQ)
//   grant   [NUM_REQ-1:0]  one-hot grant, zero when nothing is valid
//   id      [ID_W_C-1:0]   index of the granted requester (0 when none)
module piso_rr_arbiter
  import piso_rr_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W_C-1:0]  pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W_C-1:0]  id
);

  int idx;

  // Walk the search order backwards so the last hit written is the one
  // closest to the pointer, i.e. the winner.
  always_comb begin
    grant = '0;
    id    = '0;
    idx   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(pointer) + i) % NUM_REQ;
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        id         = ID_W_C'(idx);
      end
    end
  end

endmodule

// File: rtl/piso_rr_scheduler.sv
// Round-robin scheduler sharing one 32-bit PISO shift register among
// NUM_REQ requesters. A word is accepted per valid/ready handshake, loaded
// into the PISO, then shifted out MSB-first while the serial stream is
// tagged with valid, bit index and owner ID.
// Optional feature: define PISO_RR_GUARD_EN to insert one idle GUARD cycle
// after every frame (frame period 35 instead of 34).
// Ports:
//   Clk_In, Reset_N_In            clock, asynchronous active-low reset
//   Req_Valid_In/Req_Data_In      per-requester word and valid (packed words)
//   Req_Ready_Out                 one-hot grant, only in IDLE
//   Piso_Enable/Load/Shift/Data   controls and parallel word for the PISO
//   Serial_Valid_Out              a frame bit is on the serial line
//   Bit_Index_Out                 index of that bit (31..0)
//   Owner_Id_Out                  requester owning the current frame
//   Frame_Done_Out                pulse while bit 0 is on the line
module piso_rr_scheduler
  import piso_rr_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_C
) (
  input  logic                          Clk_In,
  input  logic                          Reset_N_In,
  input  logic [NUM_REQ-1:0]            Req_Valid_In,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In,
  output logic [NUM_REQ-1:0]            Req_Ready_Out,
  output logic                          Piso_Enable_Out,
  output logic                          Piso_Load_Out,
  output logic                          Piso_Shift_Out,
  output logic [DATA_WIDTH-1:0]         Piso_Data_Out,
  output logic                          Serial_Valid_Out,
  output logic [BIT_INDEX_W_C-1:0]      Bit_Index_Out,
  output logic [ID_W_C-1:0]             Owner_Id_Out,
  output logic                          Frame_Done_Out
);

  state_t                   state, next_state;
  logic [ID_W_C-1:0]        pointer, next_pointer, grant_id;
  logic [NUM_REQ-1:0]       grant;
  logic [BIT_INDEX_W_C-1:0] counter;
  logic                     handshake;

  piso_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
    .valid   (Req_Valid_In),
    .pointer (pointer),
    .grant   (grant),
    .id      (grant_id)
  );

  assign next_pointer = (grant_id == ID_W_C'(NUM_REQ - 1)) ? '0 : grant_id + ID_W_C'(1);

  // The PISO is enabled exactly while reset is released.
  assign Piso_Enable_Out = Reset_N_In;

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) state <= IDLE;
    else             state <= next_state;
  end

  // Ready is gated by reset so a held Valid cannot show a grant while the
  // block is in reset.
  always_comb begin
    next_state       = state;
    handshake        = 1'b0;
    Req_Ready_Out    = '0;
    Piso_Load_Out    = 1'b0;
    Piso_Shift_Out   = 1'b0;
    Serial_Valid_Out = 1'b0;
    Frame_Done_Out   = 1'b0;
    Bit_Index_Out    = '0;
    case (state)
      IDLE: begin
        if (Reset_N_In) begin
          Req_Ready_Out = grant;
          if (|grant) begin
            handshake  = 1'b1;
            next_state = LOAD;
          end
        end
      end
      LOAD: begin
        Piso_Load_Out = 1'b1;
        next_state    = SHIFT;
      end
      SHIFT: begin
        Serial_Valid_Out = 1'b1;
        Bit_Index_Out    = counter;
        if (counter != '0) begin
          Piso_Shift_Out = 1'b1;
        end else begin
          Frame_Done_Out = 1'b1;
`ifdef PISO_RR_GUARD_EN
          next_state = GUARD;
`else
          next_state = IDLE;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: the captured word and owner persist for the whole frame, so
  // the requester only has to hold its data during the handshake cycle.
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      pointer       <= '0;
      counter       <= '0;
      Piso_Data_Out <= '0;
      Owner_Id_Out  <= '0;
    end else begin
      if (handshake) begin
        Piso_Data_Out <= Req_Data_In[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        Owner_Id_Out  <= grant_id;
        pointer       <= next_pointer;
      end
      if (state == LOAD)
        counter <= BIT_INDEX_W_C'(DATA_WIDTH - 1);
      else if (state == SHIFT && counter != '0)
        counter <= counter - BIT_INDEX_W_C'(1);
    end
  end

endmodule

// File: tb/tb_piso_rr_scheduler.sv
// Directed bench for piso_rr_scheduler. A behavioural 32-bit PISO is
// modelled here so the serial line can be compared against the words sent.
// Honours PISO_RR_GUARD_EN for the expected frame period and guard cycle.
module tb_piso_rr_scheduler;
  import piso_rr_pkg::*;

`ifdef PISO_RR_GUARD_EN
  localparam int PERIOD = 35;
`else
  localparam int PERIOD = 34;
`endif

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         piso_en, piso_load, piso_shift;
  logic [31:0]  piso_data;
  logic         serial_valid;
  logic [4:0]   bit_index;
  logic [2:0]   owner_id;
  logic         frame_done;

  logic [31:0]  piso_reg;
  logic         serial;
  logic         overlap_seen;
  int           cyc;
  int           last_start;
  int           passed;
  int           failed;
  int           total;

  piso_rr_scheduler #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
    .Clk_In           (clk),
    .Reset_N_In       (rst_n),
    .Req_Valid_In     (req_valid),
    .Req_Data_In      (req_data),
    .Req_Ready_Out    (req_ready),
    .Piso_Enable_Out  (piso_en),
    .Piso_Load_Out    (piso_load),
    .Piso_Shift_Out   (piso_shift),
    .Piso_Data_Out    (piso_data),
    .Serial_Valid_Out (serial_valid),
    .Bit_Index_Out    (bit_index),
    .Owner_Id_Out     (owner_id),
    .Frame_Done_Out   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PISO: load has priority, shift moves toward the MSB output.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         piso_reg <= '0;
    else if (piso_en) begin
      if (piso_load)       piso_reg <= piso_data;
      else if (piso_shift) piso_reg <= {piso_reg[30:0], 1'b0};
    end
  end
  assign serial = piso_reg[31];

  always @(posedge clk) cyc <= cyc + 1;

  // Load and shift must never be asserted together at any sample point.
  always @(negedge clk) if (piso_load && piso_shift) overlap_seen <= 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int req, input logic [31:0] word);
    req_data[req*32 +: 32] = word;
    req_valid[req] = 1'b1;
    #1;
  endtask

  // Runs one frame from an IDLE negedge through its last serial bit (and the
  // guard cycle when enabled), checking every cycle against the word sent.
  task automatic runFrame(input int req, input logic [31:0] word, input bit keep,
                          input logic [3:0] late_mask, input bit check_period,
                          input logic [3:0] pulse_mask, input int pulse_idx);
    int start;
    applyStimulus(req, word);
    checkOutput("grant", 32'(req_ready), 32'(4'b0001 << req));
    start = cyc;
    if (check_period) checkOutput("period", 32'(start - last_start), 32'(PERIOD));
    last_start = start;
    tick();
    checkOutput("load", 32'(piso_load), 32'd1);
    checkOutput("load_data", piso_data, word);
    checkOutput("owner", 32'(owner_id), 32'(req));
    checkOutput("ready_load", 32'(req_ready), 32'd0);
    if (!keep) req_valid[req] = 1'b0;
    req_valid = req_valid | late_mask;
    tick();
    for (int k = 31; k >= 0; k--) begin
      if (k == pulse_idx)     req_valid = req_valid | pulse_mask;
      if (k == pulse_idx - 1) req_valid = req_valid & ~pulse_mask;
      #1;
      checkOutput("serial_valid", 32'(serial_valid), 32'd1);
      checkOutput("bit_index", 32'(bit_index), 32'(k));
      checkOutput("serial_bit", 32'(serial), 32'(word[k]));
      checkOutput("shift", 32'(piso_shift), (k != 0) ? 32'd1 : 32'd0);
      checkOutput("done", 32'(frame_done), (k == 0) ? 32'd1 : 32'd0);
      checkOutput("ready_shift", 32'(req_ready), 32'd0);
      tick();
    end
`ifdef PISO_RR_GUARD_EN
    checkOutput("guard_sv", 32'(serial_valid), 32'd0);
    checkOutput("guard_ready", 32'(req_ready), 32'd0);
    checkOutput("guard_load", 32'(piso_load), 32'd0);
    checkOutput("guard_shift", 32'(piso_shift), 32'd0);
    tick();
`endif
  endtask

  initial begin
    logic [31:0] w;
    passed = 0; failed = 0; total = 0;
    cyc = 0; last_start = 0; overlap_seen = 1'b0;
    rst_n = 1'b0; req_valid = '0; req_data = '0;

    // Reset state
    tick(); tick();
    checkOutput("rst_enable", 32'(piso_en), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_load", 32'(piso_load), 32'd0);
    checkOutput("rst_shift", 32'(piso_shift), 32'd0);
    checkOutput("rst_sv", 32'(serial_valid), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_index", 32'(bit_index), 32'd0);
    checkOutput("rst_owner", 32'(owner_id), 32'd0);
    checkOutput("rst_data", piso_data, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("enable", 32'(piso_en), 32'd1);

    // Single word from requester 0
    $display("[TB] single frame from requester 0");
    runFrame(0, 32'hA5A5_0F0F, 1'b0, 4'b0000, 1'b0, 4'b0000, -1);
    checkOutput("idle_sv", 32'(serial_valid), 32'd0);

    // Reset pulse so the pointer restarts at 0
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;

    // All four continuously valid: order 0,1,2,3,0 with fixed period
    $display("[TB] all requesters continuously valid");
    req_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    req_valid = 4'b1111;
    runFrame(0, 32'h1111_1111, 1'b1, 4'b0000, 1'b0, 4'b0000, -1);
    runFrame(1, 32'h2222_2222, 1'b1, 4'b0000, 1'b1, 4'b0000, -1);
    runFrame(2, 32'h3333_3333, 1'b1, 4'b0000, 1'b1, 4'b0000, -1);
    runFrame(3, 32'h4444_4444, 1'b1, 4'b0000, 1'b1, 4'b0000, -1);
    runFrame(0, 32'h1111_1111, 1'b1, 4'b0000, 1'b1, 4'b0000, -1);
    req_valid = '0;

    // Pointer is 1; serve 2 to move it to 3, then 3 and 0 wrap, 1 raised late
    $display("[TB] pointer wrap");
    runFrame(2, 32'hCAFE_0002, 1'b0, 4'b0000, 1'b0, 4'b0000, -1);
    req_data[0 +: 32] = 32'h0000_00F0;
    req_valid = 4'b1001;
    runFrame(3, 32'h8000_0003, 1'b0, 4'b0010, 1'b0, 4'b0000, -1);
    req_data[32 +: 32] = 32'h1234_5678;
    runFrame(0, 32'h0000_00F0, 1'b0, 4'b0000, 1'b0, 4'b0000, -1);
    runFrame(1, 32'h1234_5678, 1'b0, 4'b0000, 1'b0, 4'b0000, -1);
    checkOutput("wrap_idle_ready", 32'(req_ready), 32'd0);

    // Reset in the middle of a frame (pointer is 2, grant 2 moves it to 3)
    $display("[TB] reset mid-frame");
    w = 32'hDEAD_BEEF;
    applyStimulus(2, w);
    checkOutput("mid_grant", 32'(req_ready), 32'b0100);
    tick(); tick();
    for (int i = 0; i < 14; i++) tick();
    checkOutput("mid_index", 32'(bit_index), 32'd17);
    checkOutput("mid_bit", 32'(serial), 32'(w[17]));
    req_data[96 +: 32] = 32'h0BAD_F00D;
    req_valid[3] = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_enable", 32'(piso_en), 32'd0);
    checkOutput("mid_load", 32'(piso_load), 32'd0);
    checkOutput("mid_shift", 32'(piso_shift), 32'd0);
    checkOutput("mid_sv", 32'(serial_valid), 32'd0);
    checkOutput("mid_done", 32'(frame_done), 32'd0);
    checkOutput("mid_rst_index", 32'(bit_index), 32'd0);
    checkOutput("mid_owner", 32'(owner_id), 32'd0);
    checkOutput("mid_data", piso_data, 32'd0);
    checkOutput("mid_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_grant", 32'(req_ready), 32'b0100);
    runFrame(2, w, 1'b0, 4'b0000, 1'b0, 4'b0000, -1);
    runFrame(3, 32'h0BAD_F00D, 1'b0, 4'b0000, 1'b0, 4'b0000, -1);

    // Back-to-back frames from requester 1 (pointer is 0)
    $display("[TB] back-to-back requester 1");
    runFrame(1, 32'h5A5A_C3C3, 1'b1, 4'b0000, 1'b0, 4'b0000, -1);
    runFrame(1, 32'h5A5A_C3C3, 1'b0, 4'b0000, 1'b1, 4'b0000, -1);

    // One-cycle valid pulse from requester 2 during SHIFT is not served
    $display("[TB] valid pulse during shift");
    runFrame(0, 32'h0F0F_F0F0, 1'b0, 4'b0000, 1'b0, 4'b0100, 10);
    for (int i = 0; i < 3; i++) begin
      checkOutput("pulse_ready", 32'(req_ready), 32'd0);
      checkOutput("pulse_load", 32'(piso_load), 32'd0);
      checkOutput("pulse_sv", 32'(serial_valid), 32'd0);
      tick();
    end

    checkOutput("load_shift_overlap", 32'(overlap_seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
